// File: rtl/key_pulse_pkg.sv
// Shared types and default parameters for the pushbutton pulse source.
package key_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_DEBOUNCE_CYCLES  = 1_000_000;
  localparam int DEF_IRQ_EVERY        = 10;
  localparam int DEF_IRQ_PULSE_CYCLES = 4;

endpackage

// File: rtl/key_debounce.sv
// Synchronizer plus debounce FSM for one active-low pushbutton.
//   state        | meaning
//   IDLE         | key released and stable
//   PRESS_WAIT   | key seen low, counting stable-low cycles
//   PRESSED      | press accepted, strobe already issued
//   RELEASE_WAIT | key seen high, counting stable-high cycles
module key_debounce
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Entering a wait state counts as the first stable cycle, so the last is D-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!synced) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (synced)                 state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = PRESSED;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      PRESSED: begin
        if (synced) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!synced)                state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_d = (state_q == PRESS_WAIT) && !synced && (cnt_q == CNT_LAST);
  end

  assign press = press_q;

endmodule

// File: rtl/key_pulse_source.sv
// Two debounced pushbuttons feeding the upcounter: a count pulse per press
// and an IRQ pulse from a dedicated key or every N-th counted press.
module key_pulse_source
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int IRQ_EVERY        = DEF_IRQ_EVERY,
  parameter int IRQ_PULSE_CYCLES = DEF_IRQ_PULSE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_count_n,
  input  logic key_irq_n,
  output logic counter_pulse,
  output logic irq_pulse,
  output logic [$clog2((IRQ_EVERY > 2) ? IRQ_EVERY : 2)-1:0] press_count
);

  localparam int PC_W  = $clog2((IRQ_EVERY > 2) ? IRQ_EVERY : 2);
  localparam int TMR_W = $clog2(IRQ_PULSE_CYCLES + 1);
  localparam logic [PC_W-1:0]  PC_LAST     = PC_W'(IRQ_EVERY - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(IRQ_PULSE_CYCLES);
  localparam bit               PERIODIC_EN = (IRQ_EVERY != 0);

  logic             cnt_press, irq_press;
  logic             periodic_trig;
  logic             cp_q, cp_d;
  logic             irq_q, irq_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  key_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_count (
    .clk  (clk),
    .reset(reset),
    .key_n(key_count_n),
    .press(cnt_press)
  );

  key_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_irq (
    .clk  (clk),
    .reset(reset),
    .key_n(key_irq_n),
    .press(irq_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cp_q  <= 1'b0;
      irq_q <= 1'b0;
      pc_q  <= '0;
      tmr_q <= '0;
    end else begin
      cp_q  <= cp_d;
      irq_q <= irq_d;
      pc_q  <= pc_d;
      tmr_q <= tmr_d;
    end
  end

  always_comb begin
    periodic_trig = 1'b0;
    pc_d          = pc_q;
    if (cnt_press) begin
      if (PERIODIC_EN && (pc_q == PC_LAST)) begin
        pc_d          = '0;
        periodic_trig = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  // Any trigger (or both at once) reloads the timer, so a running pulse is extended, never restarted.
  always_comb begin
    if (periodic_trig || irq_press) tmr_d = TMR_LOAD;
    else if (tmr_q != '0)           tmr_d = tmr_q - TMR_W'(1);
    else                            tmr_d = '0;
    irq_d = (tmr_d != '0);
    cp_d  = cnt_press;
  end

  assign counter_pulse = cp_q;
  assign irq_pulse     = irq_q;
  assign press_count   = pc_q;

endmodule

// File: tb/tb_key_pulse_source.sv
// Directed bench for key_pulse_source with a run-length behavioural model checked every cycle.
module tb_key_pulse_source;

  localparam int S = 2;
  localparam int D = 8;
  localparam int E = 3;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_count_n = 1'b1;
  logic       key_irq_n = 1'b1;
  logic       counter_pulse;
  logic       irq_pulse;
  logic [1:0] press_count;

  always #5 clk = ~clk;

  key_pulse_source #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .IRQ_EVERY       (E),
    .IRQ_PULSE_CYCLES(P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_count_n  (key_count_n),
    .key_irq_n    (key_irq_n),
    .counter_pulse(counter_pulse),
    .irq_pulse    (irq_pulse),
    .press_count  (press_count)
  );

  int checks = 0;
  int failures = 0;
  int tcyc = 0;

  // model: delay lines, debounced level and opposite-run length per key
  bit hist_c[$];
  bit hist_i[$];
  bit lvl_c, lvl_i;
  int run_c, run_i;
  bit pend_c, pend_i;
  bit exp_cp, exp_irq;
  int exp_pc;
  int irq_end;

  // monitor
  int cp_cnt = 0, cp_last = -1;
  int irq_rises = 0, irq_rise_cyc = -1, irq_fall_cyc = -1;
  bit irq_prev = 1'b0;

  int t0, c0, r0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, tcyc);
    end
  endtask

  task automatic model_reset();
    hist_c = {};
    hist_i = {};
    repeat (S) begin
      hist_c.push_back(1'b1);
      hist_i.push_back(1'b1);
    end
    lvl_c = 0; lvl_i = 0; run_c = 0; run_i = 0;
    pend_c = 0; pend_i = 0;
    exp_cp = 0; exp_irq = 0; exp_pc = 0; irq_end = 0;
  endtask

  // A level flip needs D consecutive synchronized samples at the opposite level.
  task automatic deb_step(input bit obs, inout bit lvl, inout int run, output bit strobe);
    strobe = 0;
    if ((!obs) != lvl) begin
      run++;
      if (run == D) begin
        lvl    = !obs;
        run    = 0;
        strobe = lvl;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_edge();
    bit fire_i, obs;
    exp_cp = pend_c;
    fire_i = pend_i;
    if (exp_cp) begin
      exp_pc = (exp_pc + 1) % E;
      if (exp_pc == 0) irq_end = tcyc + P;
    end
    if (fire_i) irq_end = tcyc + P;
    exp_irq = (tcyc < irq_end);
    hist_c.push_back(key_count_n);
    obs = hist_c.pop_front();
    deb_step(obs, lvl_c, run_c, pend_c);
    hist_i.push_back(key_irq_n);
    obs = hist_i.pop_front();
    deb_step(obs, lvl_i, run_i, pend_i);
  endtask

  task automatic cycle();
    @(posedge clk);
    tcyc++;
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    check("counter_pulse", int'(counter_pulse), int'(exp_cp));
    check("irq_pulse", int'(irq_pulse), int'(exp_irq));
    check("press_count", int'(press_count), exp_pc);
    if (counter_pulse) begin
      cp_cnt++;
      cp_last = tcyc;
    end
    if (irq_pulse && !irq_prev) begin
      irq_rises++;
      irq_rise_cyc = tcyc;
    end
    if (!irq_pulse && irq_prev) irq_fall_cyc = tcyc;
    irq_prev = irq_pulse;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clean_press();
    key_count_n = 1'b0;
    run(14);
    key_count_n = 1'b1;
    run(14);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    run(2);
    reset = 1'b0;
    run(2);
  endtask

  initial begin
    model_reset();
    run(3);
    check("reset_cp", int'(counter_pulse), 0);
    check("reset_irq", int'(irq_pulse), 0);
    check("reset_pc", int'(press_count), 0);
    reset = 1'b0;
    run(4);

    // clean press
    c0 = cp_cnt; t0 = tcyc;
    key_count_n = 1'b0;
    run(14);
    check("clean_pulses", cp_cnt - c0, 1);
    check("clean_latency", cp_last - (t0 + 1), 10);
    check("clean_pc", int'(press_count), 1);
    key_count_n = 1'b1;
    run(14);
    check("clean_release", cp_cnt - c0, 1);

    // short glitch
    c0 = cp_cnt;
    key_count_n = 1'b0;
    run(7);
    key_count_n = 1'b1;
    run(16);
    check("glitch_pulses", cp_cnt - c0, 0);

    // bouncy press and bouncy release
    c0 = cp_cnt;
    for (int i = 0; i < 10; i++) begin
      key_count_n = i[0];
      run(3);
    end
    t0 = tcyc;
    key_count_n = 1'b0;
    run(14);
    check("bouncy_pulses", cp_cnt - c0, 1);
    check("bouncy_latency", cp_last - (t0 + 1), 10);
    check("bouncy_pc", int'(press_count), 2);
    for (int i = 0; i < 6; i++) begin
      key_count_n = ~i[0];
      run(3);
    end
    key_count_n = 1'b1;
    run(16);
    check("bouncy_release", cp_cnt - c0, 1);

    // periodic irq
    do_reset();
    check("periodic_pc0", int'(press_count), 0);
    for (int p = 1; p <= 3; p++) begin
      r0 = irq_rises;
      clean_press();
      check("periodic_pc", int'(press_count), p % 3);
      if (p == 3) begin
        check("periodic_rises", irq_rises - r0, 1);
        check("periodic_align", irq_rise_cyc, cp_last);
        check("periodic_len", irq_fall_cyc - irq_rise_cyc, 4);
      end else begin
        check("periodic_norise", irq_rises - r0, 0);
      end
    end

    // coincident triggers
    clean_press();
    clean_press();
    r0 = irq_rises;
    key_count_n = 1'b0;
    key_irq_n = 1'b0;
    run(14);
    key_count_n = 1'b1;
    key_irq_n = 1'b1;
    run(14);
    check("coinc_rises", irq_rises - r0, 1);
    check("coinc_align", irq_rise_cyc, cp_last);
    check("coinc_len", irq_fall_cyc - irq_rise_cyc, 4);
    check("coinc_pc", int'(press_count), 0);

    // retrigger two cycles into a running pulse
    clean_press();
    clean_press();
    r0 = irq_rises;
    key_count_n = 1'b0;
    run(2);
    key_irq_n = 1'b0;
    run(14);
    key_count_n = 1'b1;
    key_irq_n = 1'b1;
    run(14);
    check("retrig_rises", irq_rises - r0, 1);
    check("retrig_len", irq_fall_cyc - irq_rise_cyc, 6);

    // reset in PRESS_WAIT at counter 5, key held across release
    clean_press();
    key_count_n = 1'b0;
    run(8);
    reset = 1'b1;
    #1;
    check("midrst_cp", int'(counter_pulse), 0);
    check("midrst_irq", int'(irq_pulse), 0);
    check("midrst_pc", int'(press_count), 0);
    model_reset();
    run(3);
    c0 = cp_cnt;
    reset = 1'b0;
    t0 = tcyc;
    run(14);
    check("midrst_pulses", cp_cnt - c0, 1);
    check("midrst_latency", cp_last - (t0 + 1), 10);
    key_count_n = 1'b1;
    run(14);
    check("midrst_release", cp_cnt - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
